// File: rtl/pb_event_pkg.sv
// Shared types and constants for the push-button event decoder.
// Holds the decoder state encoding, the hold-counter width and the
// default long-press / auto-repeat tick counts.
package pb_event_pkg;

  // Width of the tick-driven hold counter (saturates, never wraps).
  localparam int CNT_W = 8;

  // Default number of ticks of continuous hold before a long press.
  localparam int DEF_LONG_TICKS = 100;

  // Default number of ticks between auto-repeat strobes while held.
  localparam int DEF_REPEAT_TICKS = 20;

  // LOCKOUT: waiting for a release after reset (button may be held).
  // IDLE:    button up, ready for a new press.
  // PRESSED: button down, long threshold not yet reached.
  // HELD:    button down past the long threshold.
  typedef enum logic [1:0] {
    ST_LOCKOUT = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_HELD    = 2'd3
  } pb_state_t;

endpackage

// File: rtl/pb_hold_timer.sv
// Tick-enabled hold counter with synchronous clear and terminal-count
// compare. The counter saturates at all-ones instead of wrapping. The
// terminal-count flag is combinational: it is high on a tick edge where
// the counter already equals the terminal value, so the owner can act on
// that same edge.
module pb_hold_timer
  import pb_event_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] terminal,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Next count: clear has priority, then a saturating increment on tick.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en && tick && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tc = tick && (cnt_reg == terminal);

endmodule

// File: rtl/pb_event_decoder.sv
// Push-button event decoder: turns a debounced button level plus a slow
// tick strobe into press / release / short / long / auto-repeat strobes
// and a held level. All outputs are registered, so every strobe appears
// one clock after the edge that caused it.
//
// Optional feature: define PB_REPEAT_EN to enable auto-repeat strobes
// while the button stays in HELD. Without it repeat_pulse is tied low
// and the hold counter stays idle in HELD.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_debounced,
  input  logic tick,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  // Terminal counts: the compare fires on the N-th tick, i.e. when the
  // counter (which started at zero) already holds N-1.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);

  pb_state_t        state_reg;
  pb_state_t        state_next;

  logic             timer_clr;
  logic             timer_en;
  logic             timer_tc;
  logic [CNT_W-1:0] timer_terminal;
  logic             repeat_hit;

  logic             press_pulse_reg,   press_pulse_next;
  logic             release_pulse_reg, release_pulse_next;
  logic             short_pulse_reg,   short_pulse_next;
  logic             long_pulse_reg,    long_pulse_next;
  logic             repeat_pulse_reg,  repeat_pulse_next;
  logic             held_reg,          held_next;

  pb_hold_timer u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .en       (timer_en),
    .tick     (tick),
    .terminal (timer_terminal),
    .tc       (timer_tc)
  );

  // State register; reset parks the decoder in LOCKOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_LOCKOUT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A release always wins over a coincident tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOCKOUT: if (!pb_debounced) state_next = ST_IDLE;
      ST_IDLE:    if (pb_debounced)  state_next = ST_PRESSED;
      ST_PRESSED: begin
        if (!pb_debounced) begin
          state_next = ST_IDLE;
        end else if (timer_tc) begin
          state_next = ST_HELD;
        end
      end
      ST_HELD:    if (!pb_debounced) state_next = ST_IDLE;
      default:    state_next = ST_LOCKOUT;
    endcase
  end

  // Repeat detection exists only when auto-repeat is built in.
`ifdef PB_REPEAT_EN
  assign repeat_hit = (state_reg == ST_HELD) && pb_debounced && timer_tc;
  assign timer_en   = (state_reg == ST_PRESSED) || (state_reg == ST_HELD);
`else
  assign repeat_hit = 1'b0;
  assign timer_en   = (state_reg == ST_PRESSED);
`endif

  // Timer control: clear on every state change and after each repeat;
  // compare against the threshold that matters in the current state.
  always_comb begin
    timer_clr      = (state_next != state_reg) || repeat_hit;
    timer_terminal = (state_reg == ST_HELD) ? REPEAT_TC : LONG_TC;
  end

  // Output decode: values the output registers take at this edge.
  always_comb begin
    press_pulse_next   = (state_reg == ST_IDLE) && pb_debounced;
    release_pulse_next = ((state_reg == ST_PRESSED) || (state_reg == ST_HELD))
                         && !pb_debounced;
    short_pulse_next   = (state_reg == ST_PRESSED) && !pb_debounced;
    long_pulse_next    = (state_reg == ST_PRESSED) && pb_debounced && timer_tc;
    repeat_pulse_next  = repeat_hit;
    held_next          = (state_next == ST_HELD);
  end

  // Output registers; reset clears every strobe and the held level at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      short_pulse_reg   <= 1'b0;
      long_pulse_reg    <= 1'b0;
      repeat_pulse_reg  <= 1'b0;
      held_reg          <= 1'b0;
    end else begin
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
      short_pulse_reg   <= short_pulse_next;
      long_pulse_reg    <= long_pulse_next;
      repeat_pulse_reg  <= repeat_pulse_next;
      held_reg          <= held_next;
    end
  end

  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign short_pulse   = short_pulse_reg;
  assign long_pulse    = long_pulse_reg;
  assign repeat_pulse  = repeat_pulse_reg;
  assign held          = held_reg;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Self-checking bench for pb_event_decoder (LONG_TICKS=4, REPEAT_TICKS=2,
// tick every 10 clocks). A behavioural model counts ticks since the press
// and derives the expected strobes arithmetically each clock.
module tb_pb_event_decoder;

  localparam int LT          = 4;
  localparam int RT          = 2;
  localparam int TICK_PERIOD = 10;
`ifdef PB_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic pb_debounced;
  logic tick;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

  pb_event_decoder #(
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pb_debounced  (pb_debounced),
    .tick          (tick),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tick_div = 0;

  // Model state: armed = a release has been seen since reset,
  // down = decoder considers the button pressed, ticks = ticks since press.
  bit m_armed, m_down;
  int m_ticks;
  bit e_press, e_rel, e_short, e_long, e_rep, e_held;

  int obs_press, obs_rel, obs_short, obs_long, obs_rep;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_bit("press_pulse",   press_pulse,   e_press);
    check_bit("release_pulse", release_pulse, e_rel);
    check_bit("short_pulse",   short_pulse,   e_short);
    check_bit("long_pulse",    long_pulse,    e_long);
    check_bit("repeat_pulse",  repeat_pulse,  e_rep);
    check_bit("held",          held,          e_held);
  endtask

  task automatic model_reset();
    m_armed = 0; m_down = 0; m_ticks = 0;
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0; e_held = 0;
  endtask

  // Expected outputs after one clock edge, from the sampled inputs.
  task automatic model_edge(input bit pb, input bit tk);
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0;
    if (!m_armed) begin
      if (!pb) m_armed = 1;
    end else if (!m_down) begin
      if (pb) begin
        m_down = 1; m_ticks = 0; e_press = 1;
      end
    end else if (!pb) begin
      e_rel = 1; e_short = (m_ticks < LT); m_down = 0;
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == LT) e_long = 1;
      else if (REP_EN && m_ticks > LT && ((m_ticks - LT) % RT) == 0) e_rep = 1;
    end
    e_held = m_down && (m_ticks >= LT);
  endtask

  task automatic clear_obs();
    obs_press = 0; obs_rel = 0; obs_short = 0; obs_long = 0; obs_rep = 0;
  endtask

  // One clock: drive inputs, take the edge, update model, compare at +1.
  task automatic cycle(input bit pb);
    bit tk;
    tk = (tick_div == TICK_PERIOD - 1);
    pb_debounced = pb;
    tick = tk;
    @(posedge clk);
    if (rst_n) model_edge(pb, tk);
    else model_reset();
    tick_div = (tick_div + 1) % TICK_PERIOD;
    #1;
    check_outputs();
    obs_press += int'(press_pulse);
    obs_rel   += int'(release_pulse);
    obs_short += int'(short_pulse);
    obs_long  += int'(long_pulse);
    obs_rep   += int'(repeat_pulse);
  endtask

  // Keep the button down until n-1 ticks have passed and the next cycle
  // is the n-th tick (which the caller then drives).
  task automatic hold_until_nth_tick(input int n);
    int seen;
    seen = 0;
    while (!(seen == n - 1 && tick_div == TICK_PERIOD - 1)) begin
      if (tick_div == TICK_PERIOD - 1) seen++;
      cycle(1);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0);
  endtask

  initial begin
    int press_len, rel_len;
    rst_n = 1'b0;
    pb_debounced = 1'b1;
    tick = 1'b0;
    model_reset();
    clear_obs();
    #1;
    check_outputs();

    // Button held through reset: nothing until release then new press.
    for (int i = 0; i < 3; i++) cycle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) cycle(1);
    check_int("lockout_press_count", obs_press, 0);
    idle_cycles(3);
    cycle(1);
    check_bit("first_press_latency", press_pulse, 1'b1);
    cycle(1);
    check_bit("first_press_width", press_pulse, 1'b0);
    $display("txn lockout_then_press presses=%0d", obs_press);

    // Short press: two ticks then release.
    idle_cycles(5);
    clear_obs();
    cycle(1);
    hold_until_nth_tick(3);
    cycle(0);
    check_int("short_release_count", obs_rel, 1);
    check_int("short_short_count", obs_short, 1);
    check_int("short_long_count", obs_long, 0);
    $display("txn short_press press=%0d release=%0d short=%0d", obs_press, obs_rel, obs_short);

    // Long hold for nine ticks, then release.
    idle_cycles(4);
    clear_obs();
    cycle(1);
    hold_until_nth_tick(10);
    check_bit("long_held_level", held, 1'b1);
    cycle(0);
    check_int("long_long_count", obs_long, 1);
    check_int("long_repeat_count", obs_rep, REP_EN ? 2 : 0);
    check_int("long_short_count", obs_short, 0);
    check_bit("long_held_after_release", held, 1'b0);
    $display("txn long_hold long=%0d repeat=%0d release=%0d", obs_long, obs_rep, obs_rel);

    // Release on the same edge as the 4th tick.
    idle_cycles(3);
    clear_obs();
    cycle(1);
    hold_until_nth_tick(4);
    cycle(0);
    check_int("race_long_count", obs_long, 0);
    check_int("race_short_count", obs_short, 1);
    idle_cycles(2);
    cycle(1);
    check_bit("race_back_to_idle", press_pulse, 1'b1);
    $display("txn release_on_threshold long=%0d short=%0d", obs_long, obs_short);

    // Reset while held.
    hold_until_nth_tick(7);
    check_bit("pre_reset_held", held, 1'b1);
    clear_obs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < 4; i++) cycle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1);
    check_int("reset_release_count", obs_rel, 0);
    check_int("reset_press_count", obs_press, 0);
    cycle(0);
    cycle(1);
    check_bit("post_reset_press", press_pulse, 1'b1);
    idle_cycles(3);
    $display("txn reset_while_held release=%0d press=%0d", obs_rel, obs_press);

    // Randomized presses and releases, with occasional resets.
    for (int t = 0; t < 40; t++) begin
      press_len = int'($urandom_range(1, 90));
      rel_len   = int'($urandom_range(1, 25));
      clear_obs();
      for (int i = 0; i < press_len; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 1'b0;
          #1;
          model_reset();
          check_outputs();
          cycle(1);
          rst_n = 1'b1;
        end
        cycle(1);
      end
      for (int i = 0; i < rel_len; i++) cycle(0);
      $display("txn random %0d press_len=%0d rel_len=%0d long=%0d repeat=%0d short=%0d",
               t, press_len, rel_len, obs_long, obs_rep, obs_short);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
